// File: rtl/vr_log_pkg.sv
// Shared types and sizing for the log-memory write controller.
// Geometry of the circular log and the per-entry line budget live here.
package vr_log_pkg;

   localparam int LOG_DATA_W      = 512;
   localparam int LOG_DEPTH_LOG2  = 10;
   localparam int LOG_DEPTH       = 1 << LOG_DEPTH_LOG2;
   localparam int ENTRY_MAX_LINES = 8;
   localparam int CNT_W           = $clog2(ENTRY_MAX_LINES + 1);

   typedef logic [LOG_DEPTH_LOG2-1:0] log_addr_t;
   typedef logic [LOG_DEPTH_LOG2:0]   log_occ_t;
   typedef logic [CNT_W-1:0]          log_cnt_t;

   typedef struct packed {
      log_addr_t addr;
      log_cnt_t  lines;
   } entry_done_t;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } wr_state_t;

   // True when the free lines can absorb one maximum-size entry.
   function automatic logic occ_has_space(input log_occ_t occ);
      return (log_occ_t'(LOG_DEPTH) - occ) >= log_occ_t'(ENTRY_MAX_LINES);
   endfunction

endpackage

// File: rtl/vr_log_occ_tracker.sv
// Occupancy of the circular log: +1 per written line, minus reclaimed lines.
// Over-reclaim clamps to empty and reports an underflow pulse.
module vr_log_occ_tracker
   import vr_log_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    inc,
   input  logic                    reclaim_val,
   input  logic [LOG_DEPTH_LOG2:0] reclaim_lines,
   output logic                    full,
   output logic                    has_space,
   output logic                    underflow
);

   log_occ_t occ_reg;
   log_occ_t occ_sum;
   log_occ_t occ_next;
   logic     has_space_reg;
   logic     underflow_next;

   always_comb begin
      occ_sum        = occ_reg + log_occ_t'(inc);
      occ_next       = occ_sum;
      underflow_next = 1'b0;
      if (reclaim_val) begin
         if (reclaim_lines > occ_sum) begin
            occ_next       = '0;
            underflow_next = 1'b1;
         end else begin
            occ_next = occ_sum - reclaim_lines;
         end
      end
   end

   // has_space is registered alongside occ so it always reflects the stored count.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_reg       <= '0;
         has_space_reg <= 1'b0;
      end else begin
         occ_reg       <= occ_next;
         has_space_reg <= occ_has_space(occ_next);
      end
   end

   assign full      = (occ_reg == log_occ_t'(LOG_DEPTH));
   assign has_space = has_space_reg;
   assign underflow = underflow_next;

endmodule

// File: rtl/vr_log_mem_wr_ctrl.sv
// Assigns circular log addresses to entry beats, drives a one-slot registered
// memory write port, and reports each completed entry's start and length.
module vr_log_mem_wr_ctrl
   import vr_log_pkg::*;
#(
   parameter int DATA_W = LOG_DATA_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      prep_log_mem_wr_val,
   input  logic [DATA_W-1:0]         prep_log_mem_wr_data,
   input  logic                      prep_log_mem_wr_last,
   output logic                      log_mem_prep_wr_rdy,
   output logic                      datap_ctrl_log_has_space,
   output logic                      log_mem_wr_req_val,
   output logic [LOG_DEPTH_LOG2-1:0] log_mem_wr_req_addr,
   output logic [DATA_W-1:0]         log_mem_wr_req_data,
   input  logic                      log_mem_wr_req_rdy,
   input  logic                      reclaim_val,
   input  logic [LOG_DEPTH_LOG2:0]   reclaim_lines,
   output logic                      entry_done_val,
   output logic [LOG_DEPTH_LOG2-1:0] entry_done_addr,
   output logic [CNT_W-1:0]          entry_done_lines,
   output logic                      wr_err
);

   wr_state_t         state_reg;
   log_addr_t         wr_ptr_reg;
   log_addr_t         start_addr_reg;
   log_cnt_t          line_cnt_reg;
   log_cnt_t          line_cnt_next;

   logic              slot_val_reg;
   log_addr_t         slot_addr_reg;
   logic [DATA_W-1:0] slot_data_reg;

   logic              pend_val_reg;
   entry_done_t       pend_reg;
   entry_done_t       pend_next;
   logic              done_val_reg;
   entry_done_t       done_reg;
   logic              err_reg;

   logic              accept;
   logic              first_beat;
   logic              over_max;
   logic              do_write;
   logic              beat_err;
   logic              occ_full;
   logic              occ_underflow;
   logic              occ_has_space_w;

   assign log_mem_prep_wr_rdy = !slot_val_reg || log_mem_wr_req_rdy;
   assign accept     = prep_log_mem_wr_val && log_mem_prep_wr_rdy;
   assign first_beat = (state_reg == ST_IDLE);
   // Once the line budget is used up, further beats are swallowed without a write.
   assign over_max   = !first_beat && (line_cnt_reg == log_cnt_t'(ENTRY_MAX_LINES));
   assign do_write   = accept && !over_max && !occ_full;
   assign beat_err   = accept && (over_max || occ_full);

   always_comb begin
      line_cnt_next = line_cnt_reg;
      if (accept) begin
         if (first_beat) begin
            line_cnt_next = do_write ? log_cnt_t'(1) : '0;
         end else if (do_write) begin
            line_cnt_next = line_cnt_reg + log_cnt_t'(1);
         end
      end
      pend_next.addr  = first_beat ? wr_ptr_reg : start_addr_reg;
      pend_next.lines = line_cnt_next;
   end

   vr_log_occ_tracker u_occ (
      .clk           (clk),
      .rst           (rst),
      .inc           (do_write),
      .reclaim_val   (reclaim_val),
      .reclaim_lines (reclaim_lines),
      .full          (occ_full),
      .has_space     (occ_has_space_w),
      .underflow     (occ_underflow)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         wr_ptr_reg     <= '0;
         start_addr_reg <= '0;
         line_cnt_reg   <= '0;
         slot_val_reg   <= 1'b0;
         slot_addr_reg  <= '0;
         slot_data_reg  <= '0;
         pend_val_reg   <= 1'b0;
         pend_reg       <= '0;
         done_val_reg   <= 1'b0;
         done_reg       <= '0;
         err_reg        <= 1'b0;
      end else begin
         if (do_write) begin
            slot_val_reg  <= 1'b1;
            slot_addr_reg <= wr_ptr_reg;
            slot_data_reg <= prep_log_mem_wr_data;
            wr_ptr_reg    <= wr_ptr_reg + log_addr_t'(1);
         end else if (log_mem_wr_req_rdy) begin
            slot_val_reg  <= 1'b0;
         end

         // Completion is reported one cycle after the last beat is loaded.
         done_val_reg <= pend_val_reg;
         if (pend_val_reg) begin
            done_reg <= pend_reg;
         end
         pend_val_reg <= 1'b0;

         if (accept) begin
            line_cnt_reg <= line_cnt_next;
            if (first_beat) begin
               start_addr_reg <= wr_ptr_reg;
            end
            if (prep_log_mem_wr_last) begin
               state_reg    <= ST_IDLE;
               pend_val_reg <= 1'b1;
               pend_reg     <= pend_next;
            end else begin
               state_reg    <= ST_WRITE;
            end
         end

         if (beat_err || occ_underflow) begin
            err_reg <= 1'b1;
         end
      end
   end

   assign datap_ctrl_log_has_space = occ_has_space_w;
   assign log_mem_wr_req_val       = slot_val_reg;
   assign log_mem_wr_req_addr      = slot_addr_reg;
   assign log_mem_wr_req_data      = slot_data_reg;
   assign entry_done_val           = done_val_reg;
   assign entry_done_addr          = done_reg.addr;
   assign entry_done_lines         = done_reg.lines;
   assign wr_err                   = err_reg;

endmodule

// File: doc/vr_log_mem_wr_ctrl.md
Name: vr_log_mem_wr_ctrl

Overview:
Downstream of the prepare engine's log controller. Accepts log-entry beats on the prep→log-memory bus and assigns each line an address in a circular log memory. Issues registered memory write requests and tracks occupancy against a reclaim (truncate) pointer. Produces the per-entry has-space indication the upstream controller gates on, and reports each completed entry's start address and length.

Parameters:
DATA_W, 512, log line width in bits
LOG_DEPTH_LOG2, 10, log2 of log memory depth in lines
ENTRY_MAX_LINES, 8, max lines per entry; also the has-space threshold
CNT_W, $clog2(ENTRY_MAX_LINES+1), width of the entry line count

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
prep_log_mem_wr_val  in  1  entry beat valid
prep_log_mem_wr_data  in  DATA_W  entry beat data
prep_log_mem_wr_last  in  1  last beat of entry
log_mem_prep_wr_rdy  out  1  beat accepted when val&rdy
datap_ctrl_log_has_space  out  1  room for one max-size entry
log_mem_wr_req_val  out  1  memory write valid
log_mem_wr_req_addr  out  LOG_DEPTH_LOG2  memory line address
log_mem_wr_req_data  out  DATA_W  memory write data
log_mem_wr_req_rdy  in  1  memory accepts write
reclaim_val  in  1  free lines at head (truncate)
reclaim_lines  in  LOG_DEPTH_LOG2+1  lines freed
entry_done_val  out  1  one-cycle pulse, entry fully issued
entry_done_addr  out  LOG_DEPTH_LOG2  first line address of entry
entry_done_lines  out  CNT_W  lines in entry
wr_err  out  1  sticky error flag

Behaviour:
- Reset: all outputs 0; wr_ptr=0, occupancy=0, state=IDLE, output register empty. rst mid-entry discards the partial entry; no entry_done pulse is issued for it.
- Output stage: single registered slot, latency 1 cycle. log_mem_prep_wr_rdy = slot empty | log_mem_wr_req_rdy. Data, address, and valid hold stable while val&!rdy.
- The address is the wr_ptr value at beat acceptance. wr_ptr increments mod 2^LOG_DEPTH_LOG2 and wraps from DEPTH-1 to 0 with no gap.
- Occupancy counter, LOG_DEPTH_LOG2+1 bits. Each accepted beat adds 1. reclaim_val subtracts reclaim_lines.
  - Same-cycle accept and reclaim: occ_next = occ + 1 − reclaim_lines.
  - reclaim_lines > occ (after the add): clamp occ_next to 0 and set wr_err.
- datap_ctrl_log_has_space = (DEPTH − occ) >= ENTRY_MAX_LINES, computed from registered occ. Upstream samples it only at entry start.
- FSM, state IDLE:
  - First accepted beat latches entry_start_addr=wr_ptr and line_cnt=1.
  - If last is also set: single-line entry, stay in IDLE, schedule entry_done.
  - Otherwise go to WRITE.
- FSM, state WRITE:
  - Each accepted beat increments line_cnt.
  - On the last beat, schedule entry_done and return to IDLE.
- Beats beyond ENTRY_MAX_LINES are accepted, not written to memory, not counted in occupancy, and set wr_err.
- Accepting a beat while occ==DEPTH (upstream violated has_space): drop the beat and set wr_err. rdy is not deasserted.
- entry_done_val pulses one cycle after the last beat enters the output slot; address and lines are held valid during the pulse. Commit is not gated on the memory ack.
- wr_err is cleared only by rst.

Decomposition:
- Shared package vr_log_pkg: LOG_DEPTH_LOG2, ENTRY_MAX_LINES, log address and count typedefs, and the entry_done struct {addr, lines}.
- One sub-module is natural: vr_log_occ_tracker, which holds the occupancy counter, clamp/error logic, and has_space compare.
- The FSM and the output register slice live in the top.

Test Plan:
- 3-line entry from reset, memory always ready → writes to addresses 0,1,2 in consecutive cycles; entry_done pulse with addr=0, lines=3; occ=3.
- wr_ptr preset to 1022 via 1022 single-line entries with reclaims, then a 4-line entry → addresses 1022,1023,0,1; entry_done addr=1022, lines=4.
- Fill to occ=1017 → has_space=0. reclaim_lines=1 in the same cycle as a beat accept → occ stays 1017 and has_space stays 0. Next reclaim of 1 → occ=1016, has_space=1.
- log_mem_wr_req_rdy low for 5 cycles mid-entry → output data and addr stable, input rdy low after slot fills, no beat lost or duplicated.
- 10-beat entry with ENTRY_MAX_LINES=8 → 8 memory writes, entry_done lines=8, wr_err=1.
- reclaim_lines=5 with occ=2 → occ=0, wr_err=1. rst mid-entry → no entry_done, wr_ptr=0, wr_err=0.
